seq_divider_16by8: RTL and testbench

- Sequential restoring divider: unsigned 16-bit dividend by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder.
- Retires one quotient bit per clock, using a shift/trial-subtract datapath.
- Inverse companion to the sequential 8x8 multiplier; sits beside it in the arithmetic unit with the same start/done style.
- Built so a product from the multiplier can be divided back for self-check.

---
 rtl/seq_divider_16by8_if.sv | 24 ++
 rtl/seq_divider_16by8.sv | 113 +++++++++++
 tb/tb_seq_divider_16by8.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_16by8_if.sv
// rtl/seq_divider_16by8_if.sv - start/done request and result bundle for the sequential divider
interface seq_divider_16by8_if #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_divider_16by8.sv
// rtl/seq_divider_16by8.sv - restoring divider, one quotient bit per clock
module seq_divider_16by8 #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   seq_divider_16by8_if.slave  bus
);
   localparam int CNT_W = $clog2(DIVIDEND_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      count_q;
   logic [DIVISOR_W-1:0]  divisor_q;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic [DIVIDEND_W-1:0] q_q, q_d;
   logic [DIVIDEND_W-1:0] quotient_q;
   logic [DIVISOR_W-1:0]  remainder_q;
   logic                  dbz_q;
   logic                  zero_pend_q;
   logic                  busy, done;

   logic [DIVISOR_W:0]    shifted;
   logic [DIVISOR_W+1:0]  trial;
   logic                  borrow;
   logic                  unused_trial_bit;

   // Partial remainder is always < divisor, so its shifted form needs one extra bit
   // and a successful trial always lands back inside DIVISOR_W bits.
   always_comb begin
      shifted          = {rem_q, q_q[DIVIDEND_W-1]};
      trial            = {1'b0, shifted} - {2'b00, divisor_q};
      borrow           = trial[DIVISOR_W+1];
      rem_d            = borrow ? shifted[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
      q_d              = {q_q[DIVIDEND_W-2:0], ~borrow};
      unused_trial_bit = trial[DIVISOR_W];
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (zero_pend_q)
               state_d = DONE;
            else if (bus.start && (bus.divisor != '0))
               state_d = CALC;
         end
         CALC:    if (count_q == LAST_CNT) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == CALC);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         divisor_q   <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         zero_pend_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (zero_pend_q) begin
                  quotient_q  <= '1;
                  remainder_q <= '1;
                  dbz_q       <= 1'b1;
                  zero_pend_q <= 1'b0;
               end else if (bus.start) begin
                  divisor_q   <= bus.divisor;
                  q_q         <= bus.dividend;
                  rem_q       <= '0;
                  count_q     <= '0;
                  dbz_q       <= 1'b0;
                  zero_pend_q <= (bus.divisor == '0);
               end
            end
            CALC: begin
               rem_q   <= rem_d;
               q_q     <= q_d;
               count_q <= count_q + 1'b1;
               if (count_q == LAST_CNT) begin
                  quotient_q  <= q_d;
                  remainder_q <= rem_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb/tb_seq_divider_16by8.sv - self-checking bench for seq_divider_16by8
module tb_seq_divider_16by8;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [15:0] prev_q;
   logic [7:0]  prev_r;

   seq_divider_16by8_if bus ();

   seq_divider_16by8 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One division from capture to the cycle after done, optionally poking start mid-flight.
   task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int inject_at,
                          input logic [15:0] ia, input logic [7:0] ib);
      logic [15:0] eq;
      logic [7:0]  er;
      logic        ez;
      int          exp_lat, exp_busy, lat, busy_cnt, unstable, extra_done;
      if (b == 0) begin
         eq = 16'hFFFF; er = 8'hFF; ez = 1'b1; exp_lat = 1; exp_busy = 0;
      end else begin
         eq = a / 16'(b); er = 8'(a % 16'(b)); ez = 1'b0; exp_lat = 16; exp_busy = 16;
      end
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      lat = 0; busy_cnt = 0; unstable = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_cnt++;
         if (bus.quotient !== prev_q || bus.remainder !== prev_r) unstable++;
         if (lat == inject_at) begin
            bus.dividend = ia;
            bus.divisor  = ib;
            bus.start    = 1'b1;
         end
         tick();
         bus.start = 1'b0;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_busy);
      check("held_mid_op", unstable, 0);
      check("quotient", bus.quotient, eq);
      check("remainder", bus.remainder, er);
      check("div_by_zero", bus.div_by_zero, ez);
      check("busy_at_done", bus.busy, 0);
      extra_done = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done) extra_done++;
      end
      check("single_done", extra_done, 0);
      check("quotient_held", bus.quotient, eq);
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      int pulses, last_pulse, bad_iv, bad_res, unstable, spurious;
      logic [15:0] hold_q;
      logic [15:0] ra;
      logic [7:0]  rb;
      checks = 0; errors = 0;
      prev_q = '0; prev_r = '0;
      reset = 1'b1;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_dbz", bus.div_by_zero, 0);

      run_div(16'd1000, 8'd7, -1, 16'd0, 8'd0);
      run_div(16'hFFFF, 8'h01, -1, 16'd0, 8'd0);
      run_div(16'hFFFF, 8'hFF, -1, 16'd0, 8'd0);
      run_div(16'h0003, 8'hC8, -1, 16'd0, 8'd0);
      run_div(16'h1234, 8'h00, -1, 16'd0, 8'd0);
      run_div(16'd100, 8'd10, -1, 16'd0, 8'd0);
      run_div(16'd1000, 8'd7, 4, 16'd500, 8'd5);

      // Abort mid-CALC: reset lands on edge N+8.
      bus.dividend = 16'd1000; bus.divisor = 8'd7; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_quotient", bus.quotient, 0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done || bus.busy) spurious++;
         tick();
      end
      check("abort_no_done", spurious, 0);
      prev_q = '0; prev_r = '0;
      run_div(16'd81, 8'd9, -1, 16'd0, 8'd0);

      // start held high: back-to-back operations every 18 cycles.
      bus.dividend = 16'd200; bus.divisor = 8'd3; bus.start = 1'b1;
      pulses = 0; last_pulse = -1; bad_iv = 0; bad_res = 0; unstable = 0;
      hold_q = prev_q;
      for (int c = 0; c < 76; c++) begin
         tick();
         if (bus.done) begin
            if (last_pulse >= 0 && c - last_pulse != 18) bad_iv++;
            if (last_pulse < 0 && c != 16) bad_iv++;
            if (bus.quotient !== 16'd66 || bus.remainder !== 8'd2) bad_res++;
            last_pulse = c;
            pulses++;
            hold_q = 16'd66;
         end else if (bus.quotient !== hold_q) begin
            unstable++;
         end
      end
      bus.start = 1'b0;
      check("held_pulses", pulses, 4);
      check("held_interval", bad_iv, 0);
      check("held_results", bad_res, 0);
      check("held_stable", unstable, 0);
      for (int i = 0; i < 20; i++) tick();
      check("held_idle_busy", bus.busy, 0);
      prev_q = 16'd66; prev_r = 8'd2;

      for (int n = 0; n < 20; n++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 5))
            0:       rb = 8'd0;
            1:       rb = 8'($urandom_range(1, 4));
            default: rb = 8'($urandom);
         endcase
         run_div(ra, rb, -1, 16'd0, 8'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
